// File: rtl/mult_sched_pkg.sv
// Shared types and default sizes for the mult_sched scheduler and its shift-add core.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned W_DEF      = 6;
  localparam int unsigned PW_DEF     = 2 * W_DEF;
  localparam int unsigned STEP_W_DEF = $clog2(W_DEF + 1);

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  function automatic logic rr_grant(input logic [1:0] valid, input logic last_id);
    if (valid == 2'b11) begin
      return ~last_id;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/mult_sched_core.sv
// Sequential shift-add multiplier datapath: one partial-product step per step_en.
// p is the partial product after the step in progress, so the final value can be captured on the last step's edge.
module mult_core
  import mult_sched_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned SW = STEP_W_DEF
) (
  input  logic          clk_fast,
  input  logic          rst,
  input  logic          load,
  input  logic          step_en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p,
  output logic          last_step
);

  logic [PW-1:0] p_q, p_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] step_q, step_d;
  logic [PW:0]   sum;

  // Extra sum bit keeps the carry before the right shift.
  always_comb begin
    sum    = {1'b0, p_q} + (x_q[0] ? {1'b0, y_q, {W{1'b0}}} : (PW + 1)'(0));
    p      = PW'(sum >> 1);
    p_d    = p_q;
    x_d    = x_q;
    y_d    = y_q;
    step_d = step_q;
    if (load) begin
      p_d    = '0;
      x_d    = a;
      y_d    = b;
      step_d = '0;
    end else if (step_en) begin
      p_d    = p;
      x_d    = x_q >> 1;
      step_d = step_q + SW'(1);
    end
  end

  assign last_step = step_en && (step_q == SW'(W - 1));

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      p_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      step_q <= '0;
    end else begin
      p_q    <= p_d;
      x_q    <= x_d;
      y_q    <= y_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin arbiter sharing one shift-add multiplier between two requesters.
// Define MULT_SCHED_TICK_EN to pace multiplier steps with a TICK_DIV clock-enable.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned W = W_DEF
`ifdef MULT_SCHED_TICK_EN
  ,
  parameter int unsigned TICK_DIV = 4000000
`endif
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [2*W-1:0]    rsp_product,
  output logic              busy
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = $clog2(W + 1);

  state_e        state_q;
  logic          last_id_q;
  logic          id_q;
  logic          grant;
  logic          accept;
  logic          tick;
  logic          step_en;
  logic          last_step;
  logic [PW-1:0] p_next;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  assign grant = rr_grant(req_valid, last_id_q);

  // Ready is offered only in IDLE, only to the granted requester; reset blocks any accept.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && (state_q == IDLE)) begin
      req_ready[grant] = req_valid[grant];
    end
  end

  assign accept = |(req_valid & req_ready);
  assign op_a   = grant ? req1_a : req0_a;
  assign op_b   = grant ? req1_b : req0_b;

`ifdef MULT_SCHED_TICK_EN
  logic [31:0] tick_cnt_q;

  always_ff @(posedge clk_fast) begin
    if (rst || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 32'd1;
    end
  end

  assign tick = (tick_cnt_q == 32'(TICK_DIV - 1));
`else
  assign tick = 1'b1;
`endif

  assign step_en = (state_q == RUN) && tick;

  mult_core #(
    .W  (W),
    .PW (PW),
    .SW (SW)
  ) u_core (
    .clk_fast  (clk_fast),
    .rst       (rst),
    .load      (accept),
    .step_en   (step_en),
    .a         (op_a),
    .b         (op_b),
    .p         (p_next),
    .last_step (last_step)
  );

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      id_q        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_product <= '0;
      busy        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= RUN;
            id_q      <= grant;
            last_id_q <= grant;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (last_step) begin
            state_q     <= DONE;
            rsp_valid   <= 1'b1;
            rsp_id      <= id_q;
            rsp_product <= p_next;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: randomized and directed requests against a cycle-level model.
// Build with MULT_SCHED_TICK_EN defined to run the same checks with TICK_DIV=4 pacing.
`timescale 1ns/1ps
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int unsigned W  = W_DEF;
  localparam int unsigned PW = 2 * W;
`ifdef MULT_SCHED_TICK_EN
  localparam int TD = 4;
`else
  localparam int TD = 1;
`endif

  logic          clk_fast = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp_valid;
  logic          rsp_id;
  logic [PW-1:0] rsp_product;
  logic          busy;

  always #5 clk_fast = ~clk_fast;

  mult_sched #(
    .W(W)
`ifdef MULT_SCHED_TICK_EN
    ,
    .TICK_DIV(TD)
`endif
  ) dut (
    .clk_fast    (clk_fast),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  typedef struct {
    int   due;
    logic id;
    int   prod;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;

  // Model state: when the multiplier is next free, the busy window and the arbitration history.
  int   m_last_id = 1;
  int   m_free = 0;
  int   m_acc = -100;
  int   m_done = -100;
  int   m_rst_last = 0;

  logic         pend[2] = '{1'b0, 1'b0};
  logic [W-1:0] pa[2];
  logic [W-1:0] pb[2];

  always @(posedge clk_fast) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Cycle in which the result is shown: after the W-th step tick following acceptance.
  function automatic int done_cycle(input int t);
    int k = 0;
    int c = t;
    while (k < W) begin
      c++;
      if (((c - m_rst_last - 1) % TD) == TD - 1) k++;
    end
    return c + 1;
  endfunction

  // One clock cycle: drive inputs, check ready against the model, record accepts.
  task automatic step(input logic r);
    logic [1:0] exp_rdy;
    logic       g;
    @(negedge clk_fast);
    rst       = r;
    req_valid = {pend[1], pend[0]};
    req0_a    = pa[0];
    req0_b    = pb[0];
    req1_a    = pa[1];
    req1_b    = pb[1];
    #1;
    exp_rdy = 2'b00;
    g       = 1'b0;
    if (!r && (cyc >= m_free) && (req_valid != 2'b00)) begin
      if (req_valid == 2'b11) g = (m_last_id == 0);
      else                    g = req_valid[1];
      exp_rdy[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    if (r) begin
      m_rst_last = cyc;
      m_last_id  = 1;
      m_free     = cyc + 1;
      m_acc      = -100;
      m_done     = -100;
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end else if (exp_rdy != 2'b00) begin
      m_acc     = cyc;
      m_done    = done_cycle(cyc);
      m_free    = m_done + 1;
      m_last_id = int'(g);
      sb.push_back('{due: m_done, id: g, prod: int'(pa[g]) * int'(pb[g])});
      grants.push_back(int'(g));
      pend[g] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || pend[0] || pend[1] || cyc < m_free) && n < 400) begin
      step(1'b0);
      n++;
    end
    n_chk++;
    if (n >= 400) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    pend[i] = 1'b1;
    pa[i]   = W'(a);
    pb[i]   = W'(b);
  endtask

  // Monitor: compares every presented result and the held outputs against the scoreboard.
  initial begin : monitor
    int   hold_p = 0;
    logic hold_id = 1'b0;
    logic due;
    exp_t e;
    forever begin
      @(negedge clk_fast);
      if (rst_q) begin
        hold_p  = 0;
        hold_id = 1'b0;
      end
      due = (sb.size() > 0) && (sb[0].due <= cyc);
      check("rsp_valid", rsp_valid, due);
      if (due) begin
        e = sb.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_product", rsp_product, e.prod);
        hold_p  = e.prod;
        hold_id = e.id;
      end else begin
        check("rsp_product_hold", rsp_product, hold_p);
        check("rsp_id_hold", rsp_id, hold_id);
      end
      check("busy", busy, (cyc > m_acc) && (cyc <= m_done));
    end
  end

  initial begin : driver
    int base;
    int n;
    pa = '{'0, '0};
    pb = '{'0, '0};
    step(1'b1);
    step(1'b1);

    set_req(0, 6, 7);
    drain();
    set_req(0, 3, 3);
    drain();

    // Tie straight out of reset: requester 0 first.
    step(1'b1);
    base = grants.size();
    set_req(0, 63, 63);
    set_req(1, 5, 9);
    drain();
    if (grants.size() >= base + 2) begin
      check("tie_first_grant", grants[base], 0);
      check("tie_second_grant", grants[base + 1], 1);
    end

    // Both kept requesting: grants must alternate.
    base = grants.size();
    n = 0;
    while (grants.size() < base + 4 && n < 300) begin
      if (!pend[0]) set_req(0, int'(rand_op()), int'(rand_op()));
      if (!pend[1]) set_req(1, int'(rand_op()), int'(rand_op()));
      step(1'b0);
      n++;
    end
    check("alternate_count", grants.size() >= base + 4, 1);
    if (grants.size() >= base + 4) begin
      for (int j = 0; j < 4; j++) check("alternate_grant", grants[base + j], j % 2);
    end
    drain();

    set_req(0, 0, 45);
    drain();
    repeat (5) step(1'b0);
    set_req(1, 63, 1);
    drain();
    repeat (5) step(1'b0);

    // Reset during step 3 aborts the result and clears the arbitration history.
    set_req(0, 63, 63);
    while (pend[0]) step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    base = grants.size();
    set_req(0, 2, 2);
    set_req(1, 3, 3);
    drain();
    if (grants.size() > base) check("post_reset_grant", grants[base], 0);

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) set_req(i, int'(rand_op()), int'(rand_op()));
        else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
      end
      step(1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
